request_arbiter8: RTL and testbench

REQUEST_ARBITER8 -- requirements
Module: request_arbiter8

---
 rtl/request_arbiter8.sv | 101 ++++++++++
 tb/tb_request_arbiter8.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/request_arbiter8.sv
// 8-way request arbiter with registered one-hot grant, fixed-priority or
// round-robin selection, a one-cycle RELEASE gap and an optional hold limit.
module request_arbiter8 #(
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [7:0] MAX_H = 8'(MAX_HOLD);

  state_t     state, state_n;
  logic [7:0] gnt_n;
  logic [2:0] id_n, last_id, last_n;
  logic       valid_n;
  logic [7:0] hold, hold_n;
  logic [2:0] fp_win, rr_win, win;
  logic       rr_found;
  logic       limit;

  // Fixed priority: ascending scan so the highest set index is the last write.
  always_comb begin
    fp_win = '0;
    for (int i = 0; i < 8; i++)
      if (req[i]) fp_win = 3'(i);
  end

  // Round-robin: scan downward starting just below the previous grantee.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= 8; k++)
      if (!rr_found && req[3'(last_id - 3'(k))]) begin
        rr_win   = 3'(last_id - 3'(k));
        rr_found = 1'b1;
      end
  end

  assign win   = (RR_MODE != 0) ? rr_win : fp_win;
  assign limit = (MAX_H != 8'd0) && (hold == MAX_H) && (|(req & ~gnt));

  always_comb begin
    state_n = state;
    gnt_n   = '0;
    id_n    = '0;
    valid_n = 1'b0;
    last_n  = last_id;
    hold_n  = hold;
    case (state)
      GRANT: begin
        if (done || !req[gnt_id] || limit) begin
          state_n = RELEASE;
        end else begin
          gnt_n   = gnt;
          id_n    = gnt_id;
          valid_n = 1'b1;
          hold_n  = (hold == 8'hFF) ? hold : hold + 8'd1;
        end
      end
      default: begin
        if (|req) begin
          state_n = GRANT;
          gnt_n   = 8'b1 << win;
          id_n    = win;
          valid_n = 1'b1;
          last_n  = win;
          hold_n  = 8'd1;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      last_id   <= '0;
      hold      <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_id    <= id_n;
      gnt_valid <= valid_n;
      last_id   <= last_n;
      hold      <= hold_n;
    end
  end

endmodule

// File: tb/tb_request_arbiter8.sv
// Directed bench: a fixed-priority instance and a round-robin instance with a
// short hold limit, sharing clock and reset.
module tb_request_arbiter8;

  logic       clk, rst_n;
  logic [7:0] req0, req1;
  logic       done0, done1;
  logic [7:0] gnt0, gnt1;
  logic [2:0] id0, id1;
  logic       v0, v1;
  int         n_assert = 0;
  int         n_fail   = 0;

  request_arbiter8 #(.RR_MODE(0), .MAX_HOLD(16)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(req0), .done(done0),
    .gnt(gnt0), .gnt_id(id0), .gnt_valid(v0));

  request_arbiter8 #(.RR_MODE(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req1), .done(done1),
    .gnt(gnt1), .gnt_id(id1), .gnt_valid(v1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // valid=0 implies gnt=0 and gnt_id=0
  task automatic chk_fp(input string tag, input logic valid, input logic [2:0] id);
    logic [7:0] eg;
    eg = valid ? (8'b1 << id) : 8'h00;
    chk({tag, "_gnt"}, gnt0, eg);
    chk({tag, "_id"}, {5'b0, id0}, valid ? {5'b0, id} : 8'h00);
    chk({tag, "_valid"}, {7'b0, v0}, {7'b0, valid});
  endtask

  task automatic chk_rr(input string tag, input logic valid, input logic [2:0] id);
    logic [7:0] eg;
    eg = valid ? (8'b1 << id) : 8'h00;
    chk({tag, "_gnt"}, gnt1, eg);
    chk({tag, "_id"}, {5'b0, id1}, valid ? {5'b0, id} : 8'h00);
    chk({tag, "_valid"}, {7'b0, v1}, {7'b0, valid});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_id;
    rst_n = 1'b0;
    req0 = '0; req1 = '0; done0 = 1'b0; done1 = 1'b0;
    #12;
    chk_fp("fp_reset", 1'b0, 3'd0);
    chk_rr("rr_reset", 1'b0, 3'd0);
    #3 rst_n = 1'b1;
    step();
    chk_fp("fp_idle", 1'b0, 3'd0);

    // Fixed priority: highest index wins
    req0 = 8'b0010_1001;
    step();
    chk_fp("fp_win5", 1'b1, 3'd5);
    done0 = 1'b1;
    step();
    chk_fp("fp_done_rel", 1'b0, 3'd0);
    done0 = 1'b0;
    step();
    chk_fp("fp_regrant5", 1'b1, 3'd5);
    // A higher non-grantee request must not preempt
    req0 = 8'b1010_1001;
    step();
    chk_fp("fp_no_preempt", 1'b1, 3'd5);
    // Grantee drops req together with done: one RELEASE only
    req0 = 8'b1000_1001;
    done0 = 1'b1;
    step();
    chk_fp("fp_dual_rel", 1'b0, 3'd0);
    done0 = 1'b0;
    step();
    chk_fp("fp_win7", 1'b1, 3'd7);
    req0 = 8'h00;
    step();
    chk_fp("fp_drop_rel", 1'b0, 3'd0);
    step();
    chk_fp("fp_back_idle", 1'b0, 3'd0);

    // Round-robin rotation with all requesters active
    req1 = 8'hFF;
    step();
    chk_rr("rr_first7", 1'b1, 3'd7);
    exp_id = 3'd7;
    for (int n = 0; n < 8; n++) begin
      done1 = 1'b1;
      step();
      chk_rr("rr_gap", 1'b0, 3'd0);
      done1 = 1'b0;
      exp_id = exp_id - 3'd1;
      step();
      chk_rr("rr_rot", 1'b1, exp_id);
    end
    req1 = 8'h00;
    step();
    chk_rr("rr_drop_rel", 1'b0, 3'd0);
    step();
    chk_rr("rr_idle", 1'b0, 3'd0);

    // Hold limit with another request pending
    req1 = 8'h0A;
    step();
    chk_rr("rr_hold_g1", 1'b1, 3'd3);
    for (int n = 0; n < 3; n++) begin
      step();
      chk_rr("rr_hold_keep", 1'b1, 3'd3);
    end
    step();
    chk_rr("rr_hold_rel", 1'b0, 3'd0);
    step();
    chk_rr("rr_hold_next1", 1'b1, 3'd1);

    // Hold limit must not fire when nobody else is waiting
    req1 = 8'h08;
    step();
    chk_rr("rr_drop1_rel", 1'b0, 3'd0);
    step();
    chk_rr("rr_solo3", 1'b1, 3'd3);
    for (int n = 0; n < 6; n++) begin
      step();
      chk_rr("rr_solo_hold", 1'b1, 3'd3);
    end

    // Asynchronous reset mid-grant
    #2 rst_n = 1'b0;
    #1;
    chk_rr("rr_async_rst", 1'b0, 3'd0);
    req1 = 8'h01;
    @(posedge clk);
    #2;
    chk_rr("rr_held_rst", 1'b0, 3'd0);
    rst_n = 1'b1;
    step();
    chk_rr("rr_post_rst0", 1'b1, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
